// File: rtl/d_drain_pkg.sv
// Shared types for the D0/D1 drain/merge block: controller state encoding and
// read-source select values.
package d_drain_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/drain_buffer.sv
// Small synchronous FIFO holding merged words until the downstream stage takes
// them; occupancy is exposed only as a count.
module drain_buffer #(
  parameter int data_width    = 6,
  parameter int address_width = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [data_width-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  output logic [data_width-1:0]    rd_data_o,
  output logic [address_width:0]   count_o
);

  localparam int DEPTH = 2 ** address_width;

  logic [data_width-1:0]    mem_q [DEPTH];
  logic [address_width-1:0] wr_ptr_q, rd_ptr_q;
  logic [address_width:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + (address_width)'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + (address_width)'(1);
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + (address_width+1)'(1);
        2'b01:   count_q <= count_q - (address_width+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/d_drain_logic.sv
// Drains the D0/D1 destination FIFOs and merges them into one valid/ready stream.
// Build option FIXED_PRIO_EN: D0 strictly preferred over D1 instead of round-robin.
//
// state  | meaning
// RESET  | just out of reset, nothing popped
// INIT   | configuration, threshold latched from umbral_out
// IDLE   | both sources empty, pipeline and buffer drained
// ACTIVE | moving words from D0/D1 to the output
// ERROR  | a source FIFO flagged an error; frozen until reset
module d_drain_logic
  import d_drain_pkg::*;
#(
  parameter int data_width    = 6,
  parameter int address_width = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [address_width:0]  umbral_out,
  input  logic                    empty_fifo_D0,
  input  logic                    empty_fifo_D1,
  input  logic [data_width-1:0]   data_out_D0,
  input  logic [data_width-1:0]   data_out_D1,
  input  logic                    error_D0,
  input  logic                    error_D1,
  output logic                    D0_pop,
  output logic                    D1_pop,
  output logic [data_width-1:0]   data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out
);

  localparam logic [address_width:0] DEPTH_C = (address_width+1)'(2 ** address_width);

  state_e                   state_q, state_d;
  logic [address_width:0]   thr_q, thr_d;
  logic                     inflight_q, inflight_d;
  logic                     src_q, src_d;
  logic [address_width:0]   count;
  logic [address_width+1:0] occ;
  logic [data_width-1:0]    rd_data, wr_data;
  logic                     grant, pop_ok, do_pop, wr_en, rd_en;
  logic                     any_err, any_avail;

  assign any_err   = error_D0 | error_D1;
  assign any_avail = ~empty_fifo_D0 | ~empty_fifo_D1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (any_avail) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!any_avail && !inflight_q && count == '0) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    if (state_q != ST_RESET && any_err) state_d = ST_ERROR;
  end

`ifdef FIXED_PRIO_EN
  assign grant = empty_fifo_D0 ? SRC_D1 : SRC_D0;
`else
  logic last_q, last_d;

  always_comb begin
    if (!empty_fifo_D0 && !empty_fifo_D1) grant = ~last_q;
    else if (!empty_fifo_D0)              grant = SRC_D0;
    else                                  grant = SRC_D1;
    last_d = do_pop ? grant : last_q;
  end

  // Starting at D1 makes D0 the first winner after reset.
  always_ff @(posedge clk) begin
    if (reset) last_q <= SRC_D1;
    else       last_q <= last_d;
  end
`endif

  // Counting the in-flight word keeps the buffer from overflowing when it lands.
  assign occ    = {1'b0, count} + {{(address_width+1){1'b0}}, inflight_q};
  assign pop_ok = (state_q == ST_IDLE || state_q == ST_ACTIVE) && any_avail &&
                  (occ < {1'b0, thr_q});

  always_comb begin
    D0_pop     = pop_ok && (grant == SRC_D0);
    D1_pop     = pop_ok && (grant == SRC_D1);
    valid_out  = (count != '0) && (state_q != ST_ERROR);
    data_out   = valid_out ? rd_data : '0;
    idle_out   = (state_q == ST_IDLE);
    active_out = (state_q == ST_ACTIVE);
    error_out  = (state_q == ST_ERROR);
  end

  assign do_pop  = D0_pop | D1_pop;
  assign wr_en   = inflight_q && (state_q != ST_ERROR);
  assign wr_data = (src_q == SRC_D1) ? data_out_D1 : data_out_D0;
  assign rd_en   = valid_out & ready_in;

  always_comb begin
    thr_d      = thr_q;
    inflight_d = inflight_q;
    src_d      = src_q;
    if (state_q == ST_INIT) begin
      if (umbral_out == '0 || umbral_out > DEPTH_C) thr_d = DEPTH_C;
      else                                          thr_d = umbral_out;
    end
    if (state_q != ST_ERROR) begin
      inflight_d = do_pop;
      if (do_pop) src_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q      <= DEPTH_C;
      inflight_q <= 1'b0;
      src_q      <= SRC_D0;
    end else begin
      thr_q      <= thr_d;
      inflight_q <= inflight_d;
      src_q      <= src_d;
    end
  end

  drain_buffer #(
    .data_width    (data_width),
    .address_width (address_width)
  ) u_buf (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .count_o   (count)
  );

endmodule

// File: tb/tb_d_drain_logic.sv
// Directed bench for d_drain_logic: behavioural D0/D1 FIFOs plus a scoreboard of
// expected pop sources and output words.
module tb_d_drain_logic;

  localparam int DW = 6;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, init, e0, e1, err0, err1, ready_in;
  logic [AW:0]   umbral_out;
  logic [DW-1:0] d0, d1, data_out;
  logic          D0_pop, D1_pop, valid_out, idle_out, active_out, error_out;

  always #5 clk = ~clk;

  d_drain_logic #(.data_width(DW), .address_width(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .umbral_out    (umbral_out),
    .empty_fifo_D0 (e0),
    .empty_fifo_D1 (e1),
    .data_out_D0   (d0),
    .data_out_D1   (d1),
    .error_D0      (err0),
    .error_D1      (err1),
    .D0_pop        (D0_pop),
    .D1_pop        (D1_pop),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .idle_out      (idle_out),
    .active_out    (active_out),
    .error_out     (error_out)
  );

  int vecs = 0, fails = 0, cyc = 0;
  int n_pop0, n_pop1, first_pop, last_pop, first_valid;
  bit saw_active;
  logic [DW-1:0] q0[$], q1[$], exp_data[$];
  logic          exp_pop[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_pop0 = 0; n_pop1 = 0; first_pop = -1; last_pop = -1; first_valid = -1;
    saw_active = 0;
  endtask

  task automatic load0(input logic [DW-1:0] v); q0.push_back(v); e0 = 1'b0; endtask
  task automatic load1(input logic [DW-1:0] v); q1.push_back(v); e1 = 1'b0; endtask
  task automatic expect_word(input logic src, input logic [DW-1:0] v);
    exp_pop.push_back(src); exp_data.push_back(v);
  endtask

  // One clock: sample just before the edge, then advance the FIFO models.
  task automatic cycle();
    logic p0, p1;
    @(negedge clk); #4;
    p0 = D0_pop; p1 = D1_pop;
    if (active_out) saw_active = 1;
    if (valid_out && first_valid < 0) first_valid = cyc;
    if (valid_out && ready_in) begin
      if (exp_data.size() > 0) chk("data_out", data_out, exp_data.pop_front());
      else                     chk("output_expected", exp_data.size(), 1);
    end
    if (p0 || p1) begin
      chk("pop_one_hot", p0 & p1, 0);
      chk("pop_nonempty", p0 ? e0 : e1, 0);
      if (exp_pop.size() > 0) chk("pop_src", p1, exp_pop.pop_front());
      else                    chk("pop_expected", exp_pop.size(), 1);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (p0) n_pop0++; else n_pop1++;
    end
    @(posedge clk); #1;
    cyc++;
    if (p0 && q0.size() > 0) d0 = q0.pop_front();
    if (p1 && q1.size() > 0) d1 = q1.pop_front();
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_data.size() > 0; i++) cycle();
    chk({tag, "_drain"}, exp_data.size(), 0);
    chk({tag, "_pops_left"}, exp_pop.size(), 0);
  endtask

  initial begin
    reset = 1'b1; init = 1'b1; umbral_out = 3'd3; e0 = 1'b1; e1 = 1'b1;
    d0 = '0; d1 = '0; err0 = 1'b0; err1 = 1'b0; ready_in = 1'b0;
    clear_stats();
    @(posedge clk); #1;
    repeat (3) cycle();

    // reset values
    chk("rst_state", dut.state_q, 0);
    chk("rst_status", {idle_out, active_out, error_out}, 0);
    chk("rst_pops", {D0_pop, D1_pop}, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);

    reset = 1'b0;
    cycle();
    chk("init_state", dut.state_q, 1);
    chk("init_idle", idle_out, 0);
    cycle();
    chk("thr_latched", dut.thr_q, 3);

    // round-robin, loaded while still in INIT
    load0(6'h05); load0(6'h06); load1(6'h36); load1(6'h0E);
`ifdef FIXED_PRIO_EN
    expect_word(1'b0, 6'h05); expect_word(1'b0, 6'h06);
    expect_word(1'b1, 6'h36); expect_word(1'b1, 6'h0E);
`else
    expect_word(1'b0, 6'h05); expect_word(1'b1, 6'h36);
    expect_word(1'b0, 6'h06); expect_word(1'b1, 6'h0E);
`endif
    ready_in = 1'b1;
    cycle(); cycle();
    chk("init_no_pop", n_pop0 + n_pop1, 0);
    chk("init_pop_gate", {D0_pop, D1_pop}, 0);
    init = 1'b0;
    cycle();
    chk("idle_after_init", idle_out, 1);
    chk("idle_first_pop", {D0_pop, D1_pop}, 2'b10);
    drain("rr");
    chk("rr_latency", first_valid - first_pop, 2);
    chk("rr_pop_counts", {n_pop0[7:0], n_pop1[7:0]}, 16'h0202);
    cycle();
    chk("rr_back_idle", {idle_out, active_out}, 2'b10);

    // backpressure at threshold 3
    clear_stats();
    ready_in = 1'b0;
    load0(6'h11); load0(6'h12); load0(6'h13);
    load1(6'h21); load1(6'h22); load1(6'h23);
`ifdef FIXED_PRIO_EN
    expect_word(1'b0, 6'h11); expect_word(1'b0, 6'h12); expect_word(1'b0, 6'h13);
    expect_word(1'b1, 6'h21); expect_word(1'b1, 6'h22); expect_word(1'b1, 6'h23);
`else
    expect_word(1'b0, 6'h11); expect_word(1'b1, 6'h21); expect_word(1'b0, 6'h12);
    expect_word(1'b1, 6'h22); expect_word(1'b0, 6'h13); expect_word(1'b1, 6'h23);
`endif
    repeat (8) cycle();
    chk("bp_pops", n_pop0 + n_pop1, 3);
    chk("bp_valid", valid_out, 1);
    chk("bp_hold", data_out, 6'h11);
    chk("bp_active", active_out, 1);
    ready_in = 1'b1;
    drain("bp");
    chk("bp_total_pops", n_pop0 + n_pop1, 6);
    cycle();
    chk("bp_back_idle", idle_out, 1);

    // single source after re-init; threshold clamping
    reset = 1'b1; init = 1'b1; umbral_out = 3'd2;
    cycle(); cycle();
    reset = 1'b0;
    cycle(); cycle();
    chk("thr_two", dut.thr_q, 2);
    umbral_out = 3'd7;
    cycle();
    chk("thr_clamp_high", dut.thr_q, 4);
    umbral_out = 3'd0;
    cycle();
    chk("thr_clamp_zero", dut.thr_q, 4);
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      load1(6'h31 + 6'(i));
      expect_word(1'b1, 6'h31 + 6'(i));
    end
    init = 1'b0;
    cycle();
    drain("ss");
    chk("ss_no_d0", n_pop0, 0);
    chk("ss_d1_count", n_pop1, 5);
    chk("ss_back_to_back", last_pop - first_pop, 4);
    chk("ss_active_seen", saw_active, 1);
    cycle();
    chk("ss_back_idle", {idle_out, active_out}, 2'b10);

    // error during ACTIVE
    clear_stats();
    for (int i = 0; i < 6; i++) load0(6'h3A + 6'(i));
    for (int i = 0; i < 4; i++) exp_pop.push_back(1'b0);
    exp_data.push_back(6'h3A); exp_data.push_back(6'h3B);
    ready_in = 1'b1;
    cycle(); cycle(); cycle();
    chk("err_pre_active", active_out, 1);
    err0 = 1'b1;
    cycle();
    err0 = 1'b0;
    chk("err_entered", {error_out, idle_out, active_out}, 3'b100);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("err_sticky", {error_out, D0_pop, D1_pop, valid_out}, 4'b1000);
    end
    chk("err_outputs_seen", exp_data.size(), 0);
    chk("err_pops_seen", exp_pop.size(), 0);
    reset = 1'b1;
    cycle();
    chk("err_reset_state", dut.state_q, 0);
    chk("err_reset_outs", {error_out, idle_out, active_out, D0_pop, D1_pop, valid_out}, 0);
    q0.delete(); q1.delete(); e0 = 1'b1; e1 = 1'b1;
    reset = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
